// File: rtl/div_iter_unit_pkg.sv
// rtl/div_iter_unit_pkg.sv - shared types and width-N helpers for the iterative divider
package div_iter_unit_pkg;

  localparam int DIV_WIDTH = 64;
  localparam int DIV_TAG_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  typedef struct packed {
    logic [DIV_WIDTH-1:0] a;
    logic [DIV_WIDTH-1:0] b;
    logic                 is_signed;
    logic                 is_word;
    logic [DIV_TAG_W-1:0] tag;
  } div_req_t;

  // Operand as seen at width N: the upper half is dropped in W mode.
  function automatic logic [DIV_WIDTH-1:0] trunc_n(input logic [DIV_WIDTH-1:0] x,
                                                   input logic is_word);
    return is_word ? {{(DIV_WIDTH/2){1'b0}}, x[DIV_WIDTH/2-1:0]} : x;
  endfunction

  function automatic logic sign_n(input logic [DIV_WIDTH-1:0] x, input logic is_word);
    return is_word ? x[DIV_WIDTH/2-1] : x[DIV_WIDTH-1];
  endfunction

  function automatic logic [DIV_WIDTH-1:0] abs_n(input logic [DIV_WIDTH-1:0] x,
                                                 input logic is_signed,
                                                 input logic is_word);
    logic [DIV_WIDTH-1:0] v;
    v = trunc_n(x, is_word);
    if (is_signed && sign_n(x, is_word))
      v = trunc_n(-v, is_word);
    return v;
  endfunction

endpackage

// File: rtl/div_iter_unit_if.sv
// rtl/div_iter_unit_if.sv - request/response handshake bundle for the divider
interface div_iter_unit_if
  import div_iter_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int TAG_W = DIV_TAG_W
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_signed;
  logic             in_word;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_quot;
  logic [WIDTH-1:0] out_rem;
  logic             out_dbz;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_a, in_b, in_signed, in_word, in_tag, out_ready,
    input  in_ready, out_valid, out_quot, out_rem, out_dbz, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_signed, in_word, in_tag, out_ready,
    output in_ready, out_valid, out_quot, out_rem, out_dbz, out_tag
  );
endinterface

// File: rtl/div_iter_unit_step.sv
// rtl/div_iter_unit_step.sv - one radix-2 restoring iteration on {rem,quot}
module div_step
  import div_iter_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic [WIDTH-1:0] i_quot,
  input  logic [WIDTH:0]   i_div,
  output logic [WIDTH:0]   o_rem,
  output logic [WIDTH-1:0] o_quot
);
  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;
  logic           w_ge;

  assign w_shift = {i_rem[WIDTH-1:0], i_quot[WIDTH-1]};
  assign w_diff  = w_shift - i_div;
  // A set rem MSB would mean the shifted value exceeds any legal divisor.
  assign w_ge    = i_rem[WIDTH] | (w_shift >= i_div);
  assign o_rem   = w_ge ? w_diff : w_shift;
  assign o_quot  = {i_quot[WIDTH-2:0], w_ge};
endmodule

// File: rtl/div_iter_unit.sv
// rtl/div_iter_unit.sv - multi-cycle restoring UDIV/SDIV unit, X and W forms, with flush
module div_iter_unit
  import div_iter_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int TAG_W = DIV_TAG_W
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           i_flush,
  output logic           o_busy,
  div_iter_unit_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int HALF  = WIDTH / 2;

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_BUSY = BUSY;
  localparam logic [1:0] S_FIX  = FIX;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]       r_state;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH:0]   r_div;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sign_a;
  logic             r_sign_b;
  logic             r_signed;
  logic             r_word;
  logic             r_dbz;
  logic [TAG_W-1:0] r_tag;

  div_req_t         w_req;
  logic [WIDTH-1:0] w_a_n;
  logic [WIDTH-1:0] w_b_n;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH-1:0] w_min_n;
  logic [WIDTH-1:0] w_ones_n;
  logic             w_dbz;
  logic             w_ovf;
  logic [WIDTH:0]   w_rem_nxt;
  logic [WIDTH-1:0] w_quot_nxt;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;
  logic             w_neg_q;
  logic             w_neg_r;

  assign w_req = '{a: bus.in_a, b: bus.in_b, is_signed: bus.in_signed,
                   is_word: bus.in_word, tag: bus.in_tag};

  assign w_a_n    = trunc_n(w_req.a, w_req.is_word);
  assign w_b_n    = trunc_n(w_req.b, w_req.is_word);
  assign w_abs_a  = abs_n(w_req.a, w_req.is_signed, w_req.is_word);
  assign w_abs_b  = abs_n(w_req.b, w_req.is_signed, w_req.is_word);
  assign w_min_n  = w_req.is_word ? {{HALF{1'b0}}, 1'b1, {(HALF-1){1'b0}}}
                                  : {1'b1, {(WIDTH-1){1'b0}}};
  assign w_ones_n = w_req.is_word ? {{HALF{1'b0}}, {HALF{1'b1}}} : {WIDTH{1'b1}};
  assign w_dbz    = (w_b_n == '0);
  assign w_ovf    = w_req.is_signed & (w_a_n == w_min_n) & (w_b_n == w_ones_n);

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem  (r_rem),
    .i_quot (r_quot),
    .i_div  (r_div),
    .o_rem  (w_rem_nxt),
    .o_quot (w_quot_nxt)
  );

  // Sign fix-up works on magnitudes; the result is cut back to N bits afterwards.
  assign w_neg_q = r_signed & (r_sign_a ^ r_sign_b);
  assign w_neg_r = r_signed & r_sign_a;
  assign w_q_fix = trunc_n(w_neg_q ? -r_quot : r_quot, r_word);
  assign w_r_fix = trunc_n(w_neg_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0], r_word);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_rem    <= '0;
      r_quot   <= '0;
      r_div    <= '0;
      r_cnt    <= '0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_signed <= 1'b0;
      r_word   <= 1'b0;
      r_dbz    <= 1'b0;
      r_tag    <= '0;
    end else if (i_flush) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_tag    <= w_req.tag;
            r_signed <= w_req.is_signed;
            r_word   <= w_req.is_word;
            r_sign_a <= w_req.is_signed & sign_n(w_req.a, w_req.is_word);
            r_sign_b <= w_req.is_signed & sign_n(w_req.b, w_req.is_word);
            if (w_dbz) begin
              r_quot  <= '0;
              r_rem   <= {1'b0, w_a_n};
              r_dbz   <= 1'b1;
              r_state <= S_DONE;
            end else if (w_ovf) begin
              r_quot  <= w_min_n;
              r_rem   <= '0;
              r_dbz   <= 1'b0;
              r_state <= S_DONE;
            end else begin
              // W dividends sit in the top half so N shifts consume exactly N bits.
              r_quot  <= w_req.is_word ? (w_abs_a << HALF) : w_abs_a;
              r_rem   <= '0;
              r_div   <= {1'b0, w_abs_b};
              r_cnt   <= w_req.is_word ? CNT_W'(HALF) : CNT_W'(WIDTH);
              r_dbz   <= 1'b0;
              r_state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          r_rem  <= w_rem_nxt;
          r_quot <= w_quot_nxt;
          r_cnt  <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1))
            r_state <= S_FIX;
        end
        S_FIX: begin
          r_quot  <= w_q_fix;
          r_rem   <= {1'b0, w_r_fix};
          r_state <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE) & ~i_flush;
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.out_quot  = r_quot;
  assign bus.out_rem   = r_rem[WIDTH-1:0];
  assign bus.out_dbz   = r_dbz;
  assign bus.out_tag   = r_tag;
  assign o_busy        = (r_state != S_IDLE);
endmodule

// File: tb/tb_div_iter_unit.sv
// tb/tb_div_iter_unit.sv - self-checking bench for div_iter_unit
module tb_div_iter_unit;
  import div_iter_unit_pkg::*;

  localparam int W  = 64;
  localparam int TW = 5;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic flush = 1'b0;
  logic busy;

  div_iter_unit_if #(.WIDTH(W), .TAG_W(TW)) bus ();

  div_iter_unit #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .i_flush (flush),
    .o_busy  (busy),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        s;
    logic        w;
    logic [63:0] q;
    logic [63:0] r;
    logic        dbz;
    int          lat;
  } vec_t;

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    logic        dbz;
    int          lat;
  } res_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural result from plain arithmetic; latency counts the accept edge as 1.
  function automatic res_t ref_div(input logic [63:0] a, input logic [63:0] b,
                                   input logic s, input logic w);
    res_t res;
    logic [63:0] an, bn;
    logic [31:0] q32, r32;
    int sa, sb;
    longint la, lb;
    an = w ? {32'b0, a[31:0]} : a;
    bn = w ? {32'b0, b[31:0]} : b;
    res.dbz = 1'b0;
    res.lat = w ? 34 : 66;
    if (bn == 0) begin
      res.q = 0; res.r = an; res.dbz = 1'b1; res.lat = 1;
    end else if (!s) begin
      res.q = an / bn; res.r = an % bn;
    end else if (w) begin
      sa = int'(a[31:0]); sb = int'(b[31:0]);
      if (a[31:0] == 32'h8000_0000 && sb == -1) begin
        q32 = 32'h8000_0000; r32 = 0; res.lat = 1;
      end else begin
        q32 = 32'(sa / sb); r32 = 32'(sa % sb);
      end
      res.q = {32'b0, q32}; res.r = {32'b0, r32};
    end else begin
      la = longint'(a); lb = longint'(b);
      if (a == 64'h8000_0000_0000_0000 && lb == -1) begin
        res.q = a; res.r = 0; res.lat = 1;
      end else begin
        res.q = 64'(la / lb); res.r = 64'(la % lb);
      end
    end
    return res;
  endfunction

  task automatic drive_req(input logic [63:0] a, input logic [63:0] b, input logic s,
                           input logic w, input logic [TW-1:0] tag);
    bus.in_a = a; bus.in_b = b; bus.in_signed = s; bus.in_word = w; bus.in_tag = tag;
    bus.in_valid = 1'b1;
  endtask

  // Issue one request and wait (bounded) for out_valid without acknowledging it.
  task automatic issue_wait(input logic [63:0] a, input logic [63:0] b, input logic s,
                            input logic w, input logic [TW-1:0] tag, output int lat);
    @(negedge clk);
    check("in_ready_at_issue", 64'(bus.in_ready), 64'd1);
    drive_req(a, b, s, w, tag);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.out_valid) begin
      n_checks++; n_errors++;
      $display("FAIL timeout: out_valid still %0d after %0d edges, required 1", bus.out_valid, lat);
    end
  endtask

  task automatic ack();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic run_check(input string name, input logic [63:0] a, input logic [63:0] b,
                           input logic s, input logic w, input logic [TW-1:0] tag,
                           input res_t exp);
    int lat;
    issue_wait(a, b, s, w, tag, lat);
    check({name, "_quot"}, bus.out_quot, exp.q);
    check({name, "_rem"}, bus.out_rem, exp.r);
    check({name, "_dbz"}, 64'(bus.out_dbz), 64'(exp.dbz));
    check({name, "_tag"}, 64'(bus.out_tag), 64'(tag));
    check({name, "_lat"}, 64'(lat), 64'(exp.lat));
    ack();
  endtask

  vec_t vecs[12];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    res_t e;
    int lat;
    logic [63:0] q0, r0;
    logic seen;

    vecs[0]  = '{64'd100, 64'd7, 1'b0, 1'b0, 64'd14, 64'd2, 1'b0, 66};
    vecs[1]  = '{-64'sd7, 64'd2, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 66};
    vecs[2]  = '{64'd7, -64'sd2, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 1'b0, 66};
    vecs[3]  = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'd0, 1'b0, 1};
    vecs[4]  = '{64'h1234, 64'd0, 1'b0, 1'b0, 64'd0, 64'h1234, 1'b1, 1};
    vecs[5]  = '{64'hDEAD_BEEF_FFFF_FFF0, 64'h3, 1'b1, 1'b1, 64'h0000_0000_FFFF_FFFB, 64'h0000_0000_FFFF_FFFF, 1'b0, 34};
    vecs[6]  = '{64'hFFFF_FFFF_0000_0064, 64'hAAAA_AAAA_0000_0007, 1'b0, 1'b1, 64'd14, 64'd2, 1'b0, 34};
    vecs[7]  = '{64'h1111_1111_8000_0000, 64'h2222_2222_FFFF_FFFF, 1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'd0, 1'b0, 1};
    vecs[8]  = '{64'h5555_5555_0000_ABCD, 64'h1234_5678_0000_0000, 1'b0, 1'b1, 64'd0, 64'hABCD, 1'b1, 1};
    vecs[9]  = '{64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 1'b1, 1'b0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1, 1};
    vecs[10] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 66};
    vecs[11] = '{-64'sd100, -64'sd7, 1'b1, 1'b0, 64'd14, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 66};

    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_signed = 1'b0;
    bus.in_word = 1'b0; bus.in_tag = '0; bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_quot", bus.out_quot, 64'd0);
    check("rst_rem", bus.out_rem, 64'd0);
    check("rst_dbz", 64'(bus.out_dbz), 64'd0);
    check("rst_tag", 64'(bus.out_tag), 64'd0);

    for (int i = 0; i < 12; i++) begin
      e = '{vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].lat};
      run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].w, TW'(i), e);
      check($sformatf("vec%0d_idle_after", i), 64'(busy), 64'd0);
    end

    // Held result: stable outputs, no accept while DONE even with in_valid high.
    issue_wait(64'd100, 64'd7, 1'b0, 1'b0, 5'd9, lat);
    q0 = bus.out_quot; r0 = bus.out_rem;
    drive_req(64'd50, 64'd5, 1'b0, 1'b0, 5'd3);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("hold_valid", 64'(bus.out_valid), 64'd1);
      check("hold_quot", bus.out_quot, 64'd14);
      check("hold_rem", bus.out_rem, 64'd2);
      check("hold_tag", 64'(bus.out_tag), 64'd9);
      check("hold_in_ready", 64'(bus.in_ready), 64'd0);
    end
    check("hold_first_quot", q0, 64'd14);
    check("hold_first_rem", r0, 64'd2);
    bus.in_valid = 1'b0;
    ack();
    check("hold_release_idle", 64'(busy), 64'd0);

    // Flush at BUSY with count=20: 44 BUSY edges after the accept edge.
    @(negedge clk);
    drive_req(64'd100, 64'd7, 1'b0, 1'b0, 5'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (44) @(posedge clk);
    #1 flush = 1'b1;
    check("flush_busy_before", 64'(busy), 64'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy_after", 64'(busy), 64'd0);
    check("flush_out_valid", 64'(bus.out_valid), 64'd0);
    seen = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    check("flush_no_late_valid", 64'(seen), 64'd0);

    // Request coincident with flush in IDLE is refused.
    @(negedge clk);
    drive_req(64'd100, 64'd7, 1'b0, 1'b0, 5'd2);
    flush = 1'b1;
    #1 check("flush_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0; flush = 1'b0;
    check("flush_no_accept", 64'(busy), 64'd0);

    e = '{64'd14, 64'd2, 1'b0, 66};
    run_check("post_flush", 64'd100, 64'd7, 1'b0, 1'b0, 5'd17, e);

    // Flush drops a held result.
    issue_wait(64'd9, 64'd0, 1'b0, 1'b0, 5'd4, lat);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_done_valid", 64'(bus.out_valid), 64'd0);
    check("flush_done_busy", 64'(busy), 64'd0);

    // Reset while holding a result clears everything.
    issue_wait(64'd100, 64'd7, 1'b0, 1'b0, 5'd21, lat);
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    check("rst_mid_valid", 64'(bus.out_valid), 64'd0);
    check("rst_mid_quot", bus.out_quot, 64'd0);
    check("rst_mid_rem", bus.out_rem, 64'd0);
    check("rst_mid_tag", 64'(bus.out_tag), 64'd0);

    for (int i = 0; i < 150; i++) begin
      logic [63:0] a, b;
      logic s, w;
      s = 1'($urandom);
      w = 1'($urandom);
      a = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: b = {$urandom, 32'd0};
        1: b = {$urandom, 32'($urandom_range(1, 15))};
        2: b = 64'($urandom_range(1, 255));
        3: begin
          b = 64'hFFFF_FFFF_FFFF_FFFF;
          if (w) a = {$urandom, 32'h8000_0000};
          else   a = 64'h8000_0000_0000_0000;
        end
        4: b = {32'd0, $urandom};
        default: b = {$urandom, $urandom};
      endcase
      e = ref_div(a, b, s, w);
      run_check($sformatf("rnd%0d", i), a, b, s, w, TW'($urandom), e);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
